// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned MUL/MULHU/DIVU/REMU engine that borrows the execute-stage ALU:
// shift-add multiply and restoring divide, one bit per cycle, using only ADD/SUB and carry/borrow.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cf
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             sel_hi;
  // acc holds hi (multiply) or rem (divide); sh holds lo or quo; opnd holds mcand or dvsr
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]     div_s;
  logic               div_take;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]   sh_nx;

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign div_s = {acc, sh[WIDTH-1]};

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    case (state)
      S_MUL: begin
        alu_a  = acc;
        alu_b  = opnd;
        alu_op = OP_ADD;
      end
      S_DIV: begin
        alu_a  = div_s[WIDTH-1:0];
        alu_b  = opnd;
        alu_op = OP_SUB;
      end
      default: ;
    endcase
  end

  // Subtract when the shifted remainder overflowed WIDTH bits or the ALU reports no borrow
  always_comb begin
    div_take = div_s[WIDTH] | ~alu_cf;
    if (sh[0]) mul_nx = {alu_cf, alu_out, sh[WIDTH-1:1]};
    else       mul_nx = {1'b0, acc, sh[WIDTH-1:1]};
    if (state == S_MUL) begin
      acc_nx = mul_nx[2*WIDTH-1:WIDTH];
      sh_nx  = mul_nx[WIDTH-1:0];
    end else begin
      acc_nx = div_take ? alu_out : div_s[WIDTH-1:0];
      sh_nx  = {sh[WIDTH-2:0], div_take};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sel_hi <= 1'b0;
      acc    <= '0;
      sh     <= '0;
      opnd   <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel_hi <= funct[0];
            if (!funct[1]) begin
              acc   <= '0;
              sh    <= op_b;
              opnd  <= op_a;
              cnt   <= CW'(WIDTH);
              state <= S_MUL;
            end else if (op_b != '0) begin
              acc   <= '0;
              sh    <= op_a;
              opnd  <= op_b;
              cnt   <= CW'(WIDTH);
              state <= S_DIV;
            end else begin
              result <= funct[0] ? op_a : '1;
              state  <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= acc_nx;
          sh  <= sh_nx;
          cnt <= cnt - CW'(1);
          // sel_hi picks hi for MULHU and rem for REMU
          if (cnt == CW'(1)) begin
            result <= sel_hi ? acc_nx : sh_nx;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: a behavioural ALU closes the loop, stimulus pushes
// hand-computed results with their expected done cycle, and a monitor pops them on done.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   funct = 2'b00;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_cf;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cf(alu_cf)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD with carry-out, SUB with borrow-out
  logic [W:0] alu_sum;
  logic [W:0] alu_dif;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_dif = {1'b0, alu_a} - {1'b0, alu_b};
    {alu_cf, alu_out} = (alu_op == 4'b1000) ? alu_dif : alu_sum;
  end

  typedef struct {
    logic [W-1:0] val;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy || done) begin
        chk("alu_a_idle", alu_a, '0);
        chk("alu_b_idle", alu_b, '0);
        chk("alu_op_idle", 32'(alu_op), '0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result %h with no request pending", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.name, result, e.val);
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge
  task automatic issue(input string name, input logic [1:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
    exp_t e;
    e.val  = exp;
    e.name = name;
    e.cyc  = cyc + ((f[1] && b == '0) ? 1 : W + 1);
    sb.push_back(e);
    funct = f;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    funct = ~f;
    op_a  = ~a;
    op_b  = ~b;
  endtask

  // Returns at the negedge where done is high
  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done within 60", n);
    end
  endtask

  task automatic run(input string name, input logic [1:0] f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp);
    issue(name, f, a, b, exp);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), '0);
    chk("rst_done", 32'(done), '0);
    chk("rst_result", result, '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_op", 32'(alu_op), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("mul_7x6",       2'b00, 32'd7, 32'd6, 32'h0000_002A);
    run("mulhu_7x6",     2'b01, 32'd7, 32'd6, 32'h0000_0000);
    run("mulhu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mul_max",       2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run("divu_100_7",    2'b10, 32'd100, 32'd7, 32'd14);
    run("remu_100_7",    2'b11, 32'd100, 32'd7, 32'd2);
    run("divu_max_1",    2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run("remu_msb_3",    2'b11, 32'h8000_0000, 32'd3, 32'd2);
    run("divu_5_0",      2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("remu_5_0",      2'b11, 32'd5, 32'd0, 32'h0000_0005);

    // Start while busy is ignored; result still holds the previous answer
    issue("mul_3x3", 2'b00, 32'd3, 32'd3, 32'd9);
    repeat (9) @(negedge clk);
    chk("result_hold", result, 32'h0000_0005);
    funct = 2'b10;
    op_a  = 32'd9;
    op_b  = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Start during the done cycle is ignored too
    funct = 2'b00;
    op_a  = 32'd3;
    op_b  = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run("divu_9_2", 2'b10, 32'd9, 32'd2, 32'd4);

    // Asynchronous reset in the middle of a divide
    funct = 2'b10;
    op_a  = 32'd1000;
    op_b  = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), '0);
    chk("abort_done", 32'(done), '0);
    chk("abort_result", result, '0);
    chk("abort_alu_a", alu_a, '0);
    chk("abort_alu_b", alu_b, '0);
    chk("abort_alu_op", 32'(alu_op), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("mul_2x5", 2'b00, 32'd2, 32'd5, 32'd10);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100000, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle controller that runs unsigned RISC-V M-extension ops (MUL, MULHU, DIVU, REMU) on the shared combinational ALU. It uses only the ALU's ADD and SUB operations and their carry/borrow flag.
- Iterative datapath: shift-add multiply and restoring divide, one bit per cycle.
- Sits beside the execute stage and drives the ALU operand/op lines while busy. The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width. Only 32 is verified; the iteration counter is sized $clog2(WIDTH)+1.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
funct  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
op_a  input  WIDTH  multiplicand / dividend
op_b  input  WIDTH  multiplier / divisor
busy  output  1  high in MUL/DIV/DONE states
done  output  1  one-cycle pulse; result valid this cycle
result  output  WIDTH  registered result; holds until next done
alu_a  output  WIDTH  ALU operand a
alu_b  output  WIDTH  ALU operand b
alu_op  output  4  ALU opcode: 4'b0000 ADD, 4'b1000 SUB
alu_out  input  WIDTH  ALU result (combinational, same cycle)
alu_cf  input  1  ALU carry (ADD) / borrow (SUB), same cycle

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, result=0, alu_a=0, alu_b=0, alu_op=ADD; all internal registers and the counter cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 with funct[1]=0 -> latch operands and funct, cnt=WIDTH, hi=0, lo=op_b, mcand=op_a; go to MUL.
  - start=1 with funct[1]=1 and op_b!=0 -> rem=0, quo=op_a, dvsr=op_b; go to DIV.
  - start=1 with funct[1]=1 and op_b==0 -> go directly to DONE with result = DIVU: all-ones, REMU: op_a. No ALU use.
- MUL, one iteration per cycle:
  - alu_op=ADD, alu_a=hi, alu_b=mcand.
  - If lo[0]=1: {hi,lo} <= {alu_cf, alu_out, lo} >> 1. Otherwise: {hi,lo} <= {1'b0, hi, lo} >> 1.
  - cnt decrements. When cnt reaches 1, the iteration completes and the state goes to DONE.
  - result = lo for MUL, hi for MULHU; computed from the final values.
- DIV, one iteration per cycle:
  - s = {rem, quo[WIDTH-1]}, WIDTH+1 bits. alu_op=SUB, alu_a=s[WIDTH-1:0], alu_b=dvsr.
  - If s[WIDTH]=1 or alu_cf=0: rem <= alu_out, quo <= {quo[WIDTH-2:0],1}.
  - Otherwise: rem <= s[WIDTH-1:0], quo <= {quo[WIDTH-2:0],0}.
  - After WIDTH iterations go to DONE with result = quo (DIVU) or rem (REMU).
- DONE: done=1, busy=1 for exactly one cycle; then IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH+1 (MUL/DIV). Divide-by-zero: done in the cycle after edge k+1.
- Back-to-back operation: start may be asserted in the cycle done is high, but it is ignored there. The earliest accepted start is the first IDLE cycle after done.
- start while busy=1 is ignored; the in-flight operands are not disturbed. Operand changes after acceptance have no effect.
- ALU port behaviour:
  - alu_op is ADD in MUL, SUB in DIV, ADD otherwise.
  - alu_a and alu_b are 0 outside MUL/DIV.
  - alu_cf is sampled only in MUL/DIV.
- result changes only on the edge entering DONE.

Test Plan:
1. MUL 7 x 6 -> done at cycle k+33, result=0x0000002A; MULHU same operands -> 0x00000000.
2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001. This exercises alu_cf carry into hi.
3. DIVU 100/7 -> 14 (0x0E); REMU 100/7 -> 2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; REMU 0x80000000/3 -> 2. The last covers the s[WIDTH]=1 path.
4. DIVU 5/0 -> done after 2 cycles, result 0xFFFFFFFF; REMU 5/0 -> 0x00000005; alu_a, alu_b and alu_op stay at idle values throughout.
5. Start MUL 3x3, then pulse start with DIVU 9/2 at cycle 10 -> ignored, result=9. Then issue DIVU 9/2 in the cycle after done -> result 4, 33 cycles later.
6. Deassert rst_n at iteration 15 of a DIVU -> busy, done, result and alu_* are 0 immediately. After release, a new MUL 2x5 -> 10 with normal latency.
